// File: rtl/edge_skew_feeder.sv
// Vector FIFO plus per-lane skew chains that feed one edge of a systolic array.
// Optional EDGE_SKEW_FEEDER_REVERSE_EN adds a per-vector descending-skew mode.
module edge_skew_feeder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PE_PER_SIDE = 6,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*PE_PER_SIDE-1:0] in_vector,
  input  logic                              advance,
`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
  input  logic                              reverse_skew,
`endif
  output logic [DATA_WIDTH*PE_PER_SIDE-1:0] edge_out,
  output logic [PE_PER_SIDE-1:0]            edge_valid,
  output logic                              busy
);

  localparam int unsigned VecW  = DATA_WIDTH * PE_PER_SIDE;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(PE_PER_SIDE) + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  logic [VecW-1:0]  mem_q [FIFO_DEPTH];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q, occ;
  logic             fifo_empty, fifo_full, empty_next;
  logic             push, pop, bubble;
  logic [VecW-1:0]  head;
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign in_ready   = ~rst & ~fifo_full;
  assign push       = in_valid & in_ready;
  // Pop decision uses registered emptiness only: a same-cycle push is never bypassed.
  assign pop        = advance & ~fifo_empty;
  assign bubble     = advance & fifo_empty;
  assign head       = mem_q[rd_ptr_q[AddrW-1:0]];
  assign empty_next = (fifo_empty & ~push) | ((occ == (AddrW+1)'(1)) & pop & ~push);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= in_vector;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
  logic pop_rev;
  assign pop_rev = reverse_skew;
`endif

  for (genvar gi = 0; gi < PE_PER_SIDE; gi++) begin : g_lane
`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
    localparam int unsigned Len    = PE_PER_SIDE;
    localparam int unsigned RevTap = PE_PER_SIDE - 1 - gi;
`else
    localparam int unsigned Len    = gi + 1;
`endif
    logic [DATA_WIDTH-1:0] data_q [Len];
    logic                  vld_q  [Len];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < Len; j++) begin
          data_q[j] <= '0;
          vld_q[j]  <= 1'b0;
        end
      end else if (advance) begin
        data_q[0] <= pop ? head[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        vld_q[0]  <= pop;
        for (int j = 1; j < Len; j++) begin
          data_q[j] <= data_q[j-1];
          vld_q[j]  <= vld_q[j-1];
        end
      end
    end

`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
    // Each stage carries the skew direction of its vector so the lane taps the right depth.
    logic rev_q [Len];
    logic fwd_hit, rev_hit;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < Len; j++) rev_q[j] <= 1'b0;
      end else if (advance) begin
        rev_q[0] <= pop & pop_rev;
        for (int j = 1; j < Len; j++) rev_q[j] <= rev_q[j-1];
      end
    end

    assign fwd_hit = vld_q[gi] & ~rev_q[gi];
    assign rev_hit = vld_q[RevTap] & rev_q[RevTap];
    assign edge_out[gi*DATA_WIDTH +: DATA_WIDTH] =
        fwd_hit ? data_q[gi] : (rev_hit ? data_q[RevTap] : '0);
    assign edge_valid[gi] = fwd_hit | rev_hit;
`else
    assign edge_out[gi*DATA_WIDTH +: DATA_WIDTH] = data_q[gi];
    assign edge_valid[gi]                        = vld_q[gi];
`endif
  end

  // Counter tracks advances since the last valid pop; the deepest lane has
  // flushed once it has hit zero and one more advance occurs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (pop) begin
      cnt_d = CntW'(PE_PER_SIDE - 1);
    end else if (bubble && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (push) state_d = StStream;
      end
      StStream: begin
        if (empty_next) state_d = StDrain;
      end
      StDrain: begin
        if (push) begin
          state_d = StStream;
        end else if (bubble && (cnt_q == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_edge_skew_feeder.sv
// Bench for edge_skew_feeder: constant vector table, directed corner sequences and
// random traffic checked against a queue-based model of pops and advance counts.
module tb_edge_skew_feeder;

  localparam int unsigned DW    = 8;
  localparam int unsigned PE    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned VW    = DW * PE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_vector = '0;
  logic          advance = 1'b0;
  logic          reverse_skew = 1'b0;
  logic [VW-1:0] edge_out;
  logic [PE-1:0] edge_valid;
  logic          busy;

  edge_skew_feeder #(
    .DATA_WIDTH  (DW),
    .PE_PER_SIDE (PE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vector    (in_vector),
    .advance      (advance),
`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
    .reverse_skew (reverse_skew),
`endif
    .edge_out     (edge_out),
    .edge_valid   (edge_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queued vectors, plus popped vectors tagged with the advance count at their pop.
  typedef struct {
    logic [VW-1:0] vec;
    int            a0;
    logic          rev;
  } fl_t;

  logic [VW-1:0] q[$];
  fl_t           fl[$];
  int            acnt = 0;

  logic          samp_ready;
  logic [VW-1:0] samp_e;
  logic [PE-1:0] samp_v;
  logic          samp_b;

  typedef struct {
    logic          r;
    logic          v;
    logic [VW-1:0] d;
    logic          a;
    logic          rdy;
    logic [VW-1:0] e;
    logic [PE-1:0] ev;
    logic          b;
  } row_t;

  row_t rows[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [VW-1:0] d, input logic a,
                     input logic rv);
    logic          exp_ready;
    logic [VW-1:0] exp_e;
    logic [PE-1:0] exp_v;
    logic          exp_b;
    fl_t           ent;
    int            dly;
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_vector = d;
    advance = a;
    reverse_skew = rv;
    #1;
    exp_ready  = !r && (q.size() < DEPTH);
    samp_ready = in_ready;
    chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (r) begin
      q.delete();
      fl.delete();
      acnt = 0;
    end else begin
      if (a) begin
        acnt++;
        if (q.size() > 0) begin
          ent.vec = q.pop_front();
          ent.a0  = acnt;
          ent.rev = rv;
          fl.push_back(ent);
        end
      end
      if (v && exp_ready) q.push_back(d);
      while (fl.size() > 0 && acnt >= fl[0].a0 + PE) void'(fl.pop_front());
    end
    #1;
    exp_e = '0;
    exp_v = '0;
    foreach (fl[k]) begin
      for (int i = 0; i < PE; i++) begin
        dly = fl[k].rev ? (PE - 1 - i) : i;
        if (fl[k].a0 + dly == acnt) begin
          exp_e[i*DW +: DW] = fl[k].vec[i*DW +: DW];
          exp_v[i] = 1'b1;
        end
      end
    end
    exp_b  = (q.size() > 0) || (fl.size() > 0);
    samp_e = edge_out;
    samp_v = edge_valid;
    samp_b = busy;
    chk("edge_out", edge_out, exp_e);
    chk("edge_valid", edge_valid, exp_v);
    chk("busy", busy, exp_b);
  endtask

  task automatic row(input logic r, input logic v, input logic [VW-1:0] d, input logic a,
                     input logic rdy, input logic [VW-1:0] e, input logic [PE-1:0] ev,
                     input logic b);
    row_t t;
    t = '{r: r, v: v, d: d, a: a, rdy: rdy, e: e, ev: ev, b: b};
    rows.push_back(t);
  endtask

  initial begin
    // Single vector with steady advance, ascending skew, busy drop.
    row(1, 0, 32'h0,        0, 0, 32'h0,        4'h0, 0);
    row(0, 1, 32'h04030201, 0, 1, 32'h0,        4'h0, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00000001, 4'h1, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00000200, 4'h2, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00030000, 4'h4, 1);
    row(0, 0, 32'h0,        1, 1, 32'h04000000, 4'h8, 1);
    row(0, 0, 32'h0,        1, 1, 32'h0,        4'h0, 0);
    // Push with advance into an empty FIFO: bubble first, data on next advance.
    row(0, 1, 32'h44332211, 1, 1, 32'h0,        4'h0, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00000011, 4'h1, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00002200, 4'h2, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00330000, 4'h4, 1);
    row(0, 0, 32'h0,        1, 1, 32'h44000000, 4'h8, 1);
    row(0, 0, 32'h0,        1, 1, 32'h0,        4'h0, 0);
    // Toggling advance: outputs hold on idle cycles.
    row(0, 1, 32'hddccbbaa, 0, 1, 32'h0,        4'h0, 1);
    row(0, 0, 32'h0,        1, 1, 32'h000000aa, 4'h1, 1);
    row(0, 0, 32'h0,        0, 1, 32'h000000aa, 4'h1, 1);
    row(0, 0, 32'h0,        1, 1, 32'h0000bb00, 4'h2, 1);
    row(0, 0, 32'h0,        0, 1, 32'h0000bb00, 4'h2, 1);
    row(0, 0, 32'h0,        1, 1, 32'h00cc0000, 4'h4, 1);
    row(0, 0, 32'h0,        0, 1, 32'h00cc0000, 4'h4, 1);
    row(0, 0, 32'h0,        1, 1, 32'hdd000000, 4'h8, 1);
    row(0, 0, 32'h0,        1, 1, 32'h0,        4'h0, 0);

    foreach (rows[i]) begin
      cyc(rows[i].r, rows[i].v, rows[i].d, rows[i].a, 1'b0);
      chk($sformatf("tbl%0d_ready", i), samp_ready, rows[i].rdy);
      chk($sformatf("tbl%0d_edge", i), samp_e, rows[i].e);
      chk($sformatf("tbl%0d_valid", i), samp_v, rows[i].ev);
      chk($sformatf("tbl%0d_busy", i), samp_b, rows[i].b);
    end

    // Backpressure: third vector waits for the first advance to free a slot.
    cyc(1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0000000a, 0, 0);
    cyc(0, 1, 32'h0000000b, 0, 0);
    cyc(0, 1, 32'h0000000c, 0, 0);
    chk("bp_full", samp_ready, 1'b0);
    cyc(0, 1, 32'h0000000c, 1, 0);
    chk("bp_no_bypass", samp_ready, 1'b0);
    chk("bp_lane0_a", samp_e[7:0], 8'h0a);
    cyc(0, 1, 32'h0000000c, 0, 0);
    chk("bp_accept", samp_ready, 1'b1);
    cyc(0, 0, 32'h0, 1, 0);
    chk("bp_lane0_b", samp_e[7:0], 8'h0b);
    cyc(0, 0, 32'h0, 1, 0);
    chk("bp_lane0_c", samp_e[7:0], 8'h0c);
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 1, 0);
    chk("bp_idle", samp_b, 1'b0);

    // Reset mid-stream: nothing emerges afterwards.
    cyc(0, 1, 32'h11111111, 1, 0);
    cyc(0, 1, 32'h22222222, 1, 0);
    cyc(1, 0, 32'h0, 1, 0);
    chk("rst_valid", samp_v, 4'h0);
    chk("rst_busy", samp_b, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'h0, 1, 0);
      chk($sformatf("rst_after%0d", i), {samp_b, samp_v}, 5'h0);
    end

`ifdef EDGE_SKEW_FEEDER_REVERSE_EN
    cyc(0, 1, 32'h04030201, 0, 0);
    cyc(0, 0, 32'h0, 1, 1);
    chk("rev_k", samp_e, 32'h04000000);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("rev_k3", samp_e, 32'h00000001);
    cyc(0, 0, 32'h0, 1, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(63) == 0), 1'($urandom_range(1)), VW'($urandom),
          ($urandom_range(9) < 6), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_skew_feeder.md
EDGE_SKEW_FEEDER -- requirements
Module: edge_skew_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one PE operand.
REQ-002 Parameter PE_PER_SIDE, default 6, number of lanes (one per array row/column on one edge).
REQ-003 Parameter FIFO_DEPTH, default 4, input vector FIFO depth in vectors (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream vector valid.
REQ-007 in_ready  output  1  FIFO can accept a vector this cycle.
REQ-008 in_vector  input  DATA_WIDTH*PE_PER_SIDE  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 advance  input  1  array step strobe; skew pipeline and FIFO pop move only when high.
REQ-010 edge_out  output  DATA_WIDTH*PE_PER_SIDE  skewed operands to one systolic-array edge input bus, same lane packing.
REQ-011 edge_valid  output  PE_PER_SIDE  per-lane valid of edge_out.
REQ-012 busy  output  1  high while any vector is queued or in flight.

Function
REQ-013 Push occurs when in_valid && in_ready; in_ready = !fifo_full, derived from registered state only, no same-cycle bypass.
REQ-014 A push while full is impossible by handshake; in_vector is ignored when in_ready is low.
REQ-015 On advance with FIFO non-empty, the head is popped; with FIFO empty, a bubble (data 0, valid 0) is inserted into all lanes.
REQ-016 Push and pop in the same cycle are both performed; occupancy unchanged.
REQ-017 Push into an empty FIFO with advance in the same cycle: the pop sees empty (bubble); the vector pops on the next advance.
REQ-018 Lane i of a vector popped at advance edge k appears on edge_out lane i, with edge_valid[i]=1, after advance edge k+i (lane 0 registered at edge k).
REQ-019 Each lane is a chain of i+1 registers enabled by advance; without advance, edge_out and edge_valid hold.
REQ-020 FIFO read/write pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-021 FSM states: IDLE, STREAM, DRAIN; busy = (state != IDLE).
REQ-022 IDLE -> STREAM on any push; STREAM stays while FIFO non-empty or pushing.
REQ-023 Every valid pop loads drain counter with PE_PER_SIDE-1.
REQ-024 STREAM -> DRAIN when FIFO becomes empty; the counter decrements on each bubble advance.
REQ-025 DRAIN -> IDLE when the counter reaches 0 and no push; DRAIN -> STREAM on a push.
REQ-026 On entry to IDLE, all edge_valid bits are 0.
REQ-027 Data passes unmodified; no arithmetic on operands.

Reset
REQ-028 With rst high at a clock edge: FIFO emptied, all lane registers and edge_out = 0, edge_valid = 0, state = IDLE, counter = 0.
REQ-029 in_ready = 0 while rst is high, and 1 in the first cycle after release.
REQ-030 Reset mid-stream discards all queued and in-flight vectors; no partial lanes emerge afterwards.

Configuration
REQ-031 Macro EDGE_SKEW_FEEDER_REVERSE_EN defined: adds input reverse_skew (1 bit, sampled at each pop, carried with the vector).
REQ-032 When reverse_skew=1 for a vector, lane i is delayed by PE_PER_SIDE-1-i advances instead of i, for right/bottom edge feeding.
REQ-033 Macro undefined: no reverse_skew port; skew is always ascending as in REQ-018.

Verification (PE_PER_SIDE=4, DATA_WIDTH=8, FIFO_DEPTH=2)
REQ-034 Push 0x04030201, advance every cycle -> lane0=0x01 at edge k, lane1=0x02 at k+1, lane2=0x03 at k+2, lane3=0x04 at k+3; busy drops after k+3.
REQ-035 Push 3 vectors, advance held low -> in_ready=0 after 2 pushes; third vector accepted only after the first advance.
REQ-036 Push and advance in the same cycle into an empty FIFO -> bubble on lane0 at that edge; data at the following advance.
REQ-037 Stream 2 vectors, rst pulsed at k+1 -> edge_valid=0 and busy=0 from the next cycle; nothing emerges later.
REQ-038 advance toggling 1,0,1,0 -> outputs hold during 0 cycles; lane timing counts advance edges only.
REQ-039 REVERSE_EN, reverse_skew=1, push 0x04030201 -> lane3=0x04 at k, lane0=0x01 at k+3.
